qft2_measure: RTL

//  Downstream of the 2-qubit QFT emulation stage: consumes its settled out_r/out_i state vector.

---
 rtl/qft2_measure.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/qft2_measure.sv
// -----------------------------------------------------------------------------
// qft2_measure
//
// Measurement stage that follows the 2-qubit QFT emulation block. On an
// accepted start it snapshots the settled state vector, then walks it one
// amplitude per cycle computing |amp|^2 and a running cumulative
// distribution. The first basis index whose cumulative probability strictly
// exceeds an LFSR-drawn threshold is the measured outcome. The result is
// offered on a valid/ready handshake and held until the consumer takes it.
//
// Optional build macro: MEAS_NORM_CHECK_EN
//   defined   - norm_err flags |prob_total - 1.0| > norm_tol, registered when
//               the last amplitude has been accumulated, held through DONE and
//               cleared on the return to IDLE.
//   undefined - norm_err is tied low and no comparator is built.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_r, in_i  signed real/imag parts of the state vector (sample_size entries)
//   start       request one measurement, accepted only while in_ready=1
//   in_ready    high only in IDLE
//   out_valid   measurement result valid (DONE)
//   out_ready   consumer accepts the result
//   meas_idx    measured basis index
//   prob_total  unsigned sum of all |amp|^2 (fp_bit fractional bits)
//   norm_err    normalisation error flag (see macro above)
// -----------------------------------------------------------------------------
module qft2_measure #(
  parameter int                sample_size    = 4,
  parameter int                complexnum_bit = 24,
  parameter int                fp_bit         = 22,
  parameter int                idx_bit        = 2,
  parameter logic [fp_bit-1:0] lfsr_seed      = fp_bit'(1),
  parameter int                norm_tol       = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [complexnum_bit-1:0]      in_r [sample_size],
  input  logic signed [complexnum_bit-1:0]      in_i [sample_size],
  input  logic                                  start,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [idx_bit-1:0]                    meas_idx,
  output logic [complexnum_bit+idx_bit+1:0]     prob_total,
  output logic                                  norm_err
);

  localparam int CW   = complexnum_bit;
  localparam int PW   = complexnum_bit + 2;            // width of one |amp|^2
  localparam int CUMW = complexnum_bit + idx_bit + 2;  // cumulative sum width

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [fp_bit-1:0]  SEED = (lfsr_seed == '0) ? fp_bit'(1) : lfsr_seed;
  localparam logic [idx_bit-1:0] LAST = idx_bit'(sample_size - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                     state_reg,      state_next;
  logic [fp_bit-1:0]          lfsr_reg,       lfsr_next;
  logic [fp_bit-1:0]          thresh_reg,     thresh_next;
  logic [CUMW-1:0]            cum_reg,        cum_next;
  logic                       found_reg,      found_next;
  logic [idx_bit-1:0]         k_reg,          k_next;
  logic [idx_bit-1:0]         meas_idx_reg,   meas_idx_next;
  logic [CUMW-1:0]            prob_total_reg, prob_total_next;

  // Snapshot of the state vector; not reset because it is always rewritten
  // before use.
  logic signed [CW-1:0]       snap_r_reg [sample_size];
  logic signed [CW-1:0]       snap_i_reg [sample_size];

  logic                       accept;
  logic signed [CW-1:0]       r_sel, i_sel;
  logic signed [2*CW-1:0]     sq_r, sq_i;
  logic [2*CW:0]              sq_sum;
  logic [PW-1:0]              p;
  logic [CUMW-1:0]            cum_sum;
  logic [fp_bit-1:0]          lfsr_step;

  assign accept = (state_reg == IDLE) && start;

  // Fibonacci LFSR: taps on the top two bits (x^22 + x^21 + 1 by default).
  assign lfsr_step = {lfsr_reg[fp_bit-2:0], lfsr_reg[fp_bit-1] ^ lfsr_reg[fp_bit-2]};

  // |amp|^2 of the current amplitude. Both squares are non-negative (the
  // most negative input squares to 2^(2*CW-2), still positive in 2*CW
  // signed bits), so they are summed as unsigned with one guard bit and
  // truncated after the fixed-point shift.
  always_comb begin
    r_sel   = snap_r_reg[k_reg];
    i_sel   = snap_i_reg[k_reg];
    sq_r    = r_sel * r_sel;
    sq_i    = i_sel * i_sel;
    sq_sum  = {1'b0, sq_r} + {1'b0, sq_i};
    p       = PW'(sq_sum >> fp_bit);
    cum_sum = cum_reg + CUMW'(p);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int n = 0; n < sample_size; n++) begin
        snap_r_reg[n] <= in_r[n];
        snap_i_reg[n] <= in_i[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lfsr_reg       <= SEED;
      thresh_reg     <= '0;
      cum_reg        <= '0;
      found_reg      <= 1'b0;
      k_reg          <= '0;
      meas_idx_reg   <= '0;
      prob_total_reg <= '0;
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= lfsr_next;
      thresh_reg     <= thresh_next;
      cum_reg        <= cum_next;
      found_reg      <= found_next;
      k_reg          <= k_next;
      meas_idx_reg   <= meas_idx_next;
      prob_total_reg <= prob_total_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lfsr_next       = lfsr_reg;
    thresh_next     = thresh_reg;
    cum_next        = cum_reg;
    found_next      = found_reg;
    k_next          = k_reg;
    meas_idx_next   = meas_idx_reg;
    prob_total_next = prob_total_reg;
    in_ready        = 1'b0;
    out_valid       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          // The LFSR only advances on an accepted start, so the first draw
          // after reset is the seed itself.
          thresh_next = lfsr_reg;
          lfsr_next   = lfsr_step;
          cum_next    = '0;
          found_next  = 1'b0;
          k_next      = '0;
          state_next  = ACCUM;
        end
      end

      ACCUM: begin
        cum_next = cum_sum;
        // Strict compare: landing exactly on the threshold does not select k.
        if (!found_reg && (cum_sum > CUMW'(thresh_reg))) begin
          meas_idx_next = k_reg;
          found_next    = 1'b1;
        end
        if (k_reg == LAST) begin
          // Rounding can leave the total just under the threshold; fall back
          // to the last index in that case.
          if (!found_reg) begin
            meas_idx_next = LAST;
          end
          prob_total_next = cum_sum;
          state_next      = DONE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign meas_idx   = meas_idx_reg;
  assign prob_total = prob_total_reg;

`ifdef MEAS_NORM_CHECK_EN
  localparam logic [CUMW-1:0] ONE = CUMW'(1) << fp_bit;

  logic [CUMW-1:0] norm_dev;
  logic            norm_err_reg;

  assign norm_dev = (cum_sum >= ONE) ? (cum_sum - ONE) : (ONE - cum_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      norm_err_reg <= 1'b0;
    end else if ((state_reg == ACCUM) && (k_reg == LAST)) begin
      norm_err_reg <= (norm_dev > CUMW'(norm_tol));
    end else if ((state_reg == DONE) && out_ready) begin
      norm_err_reg <= 1'b0;
    end
  end

  assign norm_err = norm_err_reg;
`else
  assign norm_err = 1'b0;
`endif

endmodule
